fp_exception_int_ctrl: RTL and testbench
========================================

Name: fp_exception_int_ctrl

Overview:
- Collects the six FPU exception flags (SNaN, QNaN, div_by_zero, overflow, underflow, inexact) into pending and sticky registers.
- Applies a software mask, picks the highest-priority unmasked exception and raises an interrupt request to the machine sequencer with a cause code and handler vector.
- Tracks the handshake until the handler returns, and sits between the FPU flag outputs and the sequencer/PC logic.

Parameters:
PC_WIDTH, 32, width of irq_vector
VECTOR_BASE, 32'h0000_0100, vector for cause code 1
VECTOR_STRIDE, 4, address step between consecutive cause vectors

Ports:
clk  in  1  system clock, rising edge
interrupt_reset_n  in  1  synchronous, active-low reset
exc_valid  in  1  FPU result completes this cycle; flags are sampled only when high
SNaN  in  1  signalling-NaN flag
QNaN  in  1  quiet-NaN flag
div_by_zero  in  1  divide-by-zero flag
overflow  in  1  overflow flag
underflow  in  1  underflow flag
inexact  in  1  inexact flag
mask_we  in  1  mask write strobe
mask_wdata  in  6  new mask; bit=1 disables that source
status_clr  in  1  write-one-to-clear strobe for sticky_status/overrun
status_clr_data  in  6  bits to clear
int_ack  in  1  sequencer accepts the request
int_eoi  in  1  handler finished (end of interrupt)
irq  out  1  interrupt request
irq_cause  out  3  cause code of request in progress
irq_vector  out  PC_WIDTH  handler address
in_service  out  1  handler active
pending  out  6  exceptions awaiting service
sticky_status  out  6  accumulated flags since last clear
overrun  out  6  flag re-raised while already pending
mask  out  6  current mask

Behaviour:
- Flag bit order, all 6-bit vectors: [5]SNaN [4]QNaN [3]div_by_zero [2]overflow [1]underflow [0]inexact.
- Priority and cause codes:
  - Priority: SNaN > QNaN > div_by_zero > overflow > underflow > inexact.
  - Codes: 1=SNaN, 2=QNaN, 3=div_by_zero, 4=overflow, 5=underflow, 6=inexact, 0=none.
- Reset (interrupt_reset_n low at a rising edge, from any state):
  - FSM goes to IDLE.
  - irq=0, irq_cause=0, irq_vector=0, in_service=0.
  - pending=0, sticky_status=0, overrun=0, mask=6'b111111 (all disabled).
- Capture at each edge with exc_valid=1, for each flag bit i set:
  - pending[i]<=1 and sticky_status[i]<=1, regardless of mask.
  - If pending[i] was already 1 (and is not being cleared by ack this edge), overrun[i]<=1.
  - exc_valid=0: flags are ignored.
- status_clr: clears sticky_status and overrun bits selected by status_clr_data. A same-edge set of the same bit wins over the clear. pending is never touched by status_clr.
- mask_we: mask<=mask_wdata at the edge.
- eligible = pending & ~mask, evaluated from registered values.
- FSM:
  - IDLE: if eligible!=0 at edge, latch irq_cause = highest-priority eligible code and go to REQ.
  - REQ: irq=1. irq_cause/irq_vector are held stable; there is no preemption by newer or higher-priority flags, and a mask write does not withdraw the request. On int_ack, clear pending[cause] at that edge, go to SERVICE, irq<=0, in_service<=1.
  - SERVICE: in_service=1, irq_cause held, no new request. On int_eoi, go to IDLE, in_service<=0, irq_cause<=0.
- Latency:
  - Flag sampled at edge t → pending visible after t → irq visible after edge t+1 (when idle and unmasked).
  - After eoi at edge e, the next eligible exception raises irq after edge e+1.
- Same-edge pending interactions:
  - Ack while the same bit is re-flagged: the new set wins, pending stays 1, no overrun.
  - Ack while a different bit is flagged: both take effect.
- Ignored strobes: int_ack outside REQ, int_eoi outside SERVICE.
- irq_vector = VECTOR_BASE + (irq_cause-1)*VECTOR_STRIDE while in REQ or SERVICE; 0 in IDLE. Arithmetic is PC_WIDTH wide and wraps modulo 2^PC_WIDTH.
- A masked pending bit stays pending and raises irq as soon as it is unmasked (edge after the mask write).

Test Plan:
- Reset then mask_wdata=6'b000000; exc_valid=1 with overflow=1 at edge t → pending=6'b000100 after t; after edge t+1: irq=1, irq_cause=4, irq_vector=0x10C.
- Same cycle: SNaN=1, inexact=1 → irq_cause=1, vector 0x100. After ack+eoi → second request irq_cause=6, vector 0x114. sticky_status=6'b100001 until status_clr_data=6'b100001.
- mask=6'b111111, div_by_zero flagged → irq stays 0, pending[3]=1. Write mask=6'b110111 → irq=1 one edge later, irq_cause=3.
- In SERVICE for cause 4, flag overflow again → pending[2]=1, overrun=0. Flag overflow once more → overrun[2]=1. After eoi, new request with cause 4.
- In REQ, drive int_eoi (ignored), then flag SNaN (irq_cause stays 4), then pulse interrupt_reset_n=0 for one edge → all outputs at reset values, mask=6'b111111.
- int_ack in the same edge that re-flags the serviced bit → pending bit remains 1 and overrun remains 0.

Source files
------------

// File: rtl/fp_exception_int_ctrl.sv
// FPU exception interrupt controller: gathers the six exception flags into pending/sticky state,
// masks and prioritises them, and runs the irq -> ack -> eoi handshake with the machine sequencer.
module fp_exception_int_ctrl #(
  parameter int                     PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0]    VECTOR_BASE   = PC_WIDTH'(32'h0000_0100),
  parameter int                     VECTOR_STRIDE = 4
) (
  input  logic                clk,
  input  logic                interrupt_reset_n,
  input  logic                exc_valid,
  input  logic                SNaN,
  input  logic                QNaN,
  input  logic                div_by_zero,
  input  logic                overflow,
  input  logic                underflow,
  input  logic                inexact,
  input  logic                mask_we,
  input  logic [5:0]          mask_wdata,
  input  logic                status_clr,
  input  logic [5:0]          status_clr_data,
  input  logic                int_ack,
  input  logic                int_eoi,
  output logic                irq,
  output logic [2:0]          irq_cause,
  output logic [PC_WIDTH-1:0] irq_vector,
  output logic                in_service,
  output logic [5:0]          pending,
  output logic [5:0]          sticky_status,
  output logic [5:0]          overrun,
  output logic [5:0]          mask
);

  // Handshake: irq stays high in REQ until int_ack is seen at a rising edge; in_service stays
  // high in SERVICE until int_eoi is seen at a rising edge. Strobes outside those states are ignored.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t              state_q;
  logic                irq_q;
  logic                in_service_q;
  logic [2:0]          cause_q;
  logic [PC_WIDTH-1:0] vector_q;
  logic [5:0]          pending_q, pending_d;
  logic [5:0]          sticky_q, sticky_d;
  logic [5:0]          overrun_q, overrun_d;
  logic [5:0]          mask_q, mask_d;

  logic [5:0] flags;
  logic [5:0] set_v;
  logic [5:0] clr_v;
  logic [5:0] ack_clr;
  logic [5:0] eligible;
  logic [2:0] best_code;
  logic       ack_fire;

  function automatic logic [5:0] cause_bit(input logic [2:0] c);
    logic [5:0] top;
    top = 6'b100000;
    return top >> (c - 3'd1);
  endfunction

  function automatic logic [PC_WIDTH-1:0] vec_of(input logic [2:0] c);
    logic [PC_WIDTH-1:0] idx;
    idx = PC_WIDTH'(c) - PC_WIDTH'(1);
    return VECTOR_BASE + idx * PC_WIDTH'(VECTOR_STRIDE);
  endfunction

  assign flags    = {SNaN, QNaN, div_by_zero, overflow, underflow, inexact};
  assign set_v    = exc_valid ? flags : 6'b000000;
  assign clr_v    = status_clr ? status_clr_data : 6'b000000;
  assign ack_fire = (state_q == REQ) && int_ack;
  assign ack_clr  = ack_fire ? cause_bit(cause_q) : 6'b000000;
  assign eligible = pending_q & ~mask_q;

  // A new flag always wins over an ack clear or a status clear landing on the same edge.
  always_comb begin
    pending_d = (pending_q & ~ack_clr) | set_v;
    sticky_d  = (sticky_q & ~clr_v) | set_v;
    overrun_d = (overrun_q & ~clr_v) | (set_v & pending_q & ~ack_clr);
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_comb begin
    best_code = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (eligible[i]) best_code = 3'(6 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (!interrupt_reset_n) begin
      state_q      <= IDLE;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
      cause_q      <= 3'd0;
      vector_q     <= '0;
      pending_q    <= 6'b000000;
      sticky_q     <= 6'b000000;
      overrun_q    <= 6'b000000;
      mask_q       <= 6'b111111;
    end else begin
      pending_q <= pending_d;
      sticky_q  <= sticky_d;
      overrun_q <= overrun_d;
      mask_q    <= mask_d;
      case (state_q)
        IDLE: begin
          if (eligible != 6'b000000) begin
            state_q  <= REQ;
            irq_q    <= 1'b1;
            cause_q  <= best_code;
            vector_q <= vec_of(best_code);
          end
        end
        REQ: begin
          if (int_ack) begin
            state_q      <= SERVICE;
            irq_q        <= 1'b0;
            in_service_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (int_eoi) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
            cause_q      <= 3'd0;
            vector_q     <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          irq_q        <= 1'b0;
          in_service_q <= 1'b0;
          cause_q      <= 3'd0;
          vector_q     <= '0;
        end
      endcase
    end
  end

  assign irq           = irq_q;
  assign irq_cause     = cause_q;
  assign irq_vector    = vector_q;
  assign in_service    = in_service_q;
  assign pending       = pending_q;
  assign sticky_status = sticky_q;
  assign overrun       = overrun_q;
  assign mask          = mask_q;

endmodule

// File: tb/tb_fp_exception_int_ctrl.sv
// Directed bench for fp_exception_int_ctrl: linear steps with hand-computed expectations.
module tb_fp_exception_int_ctrl;

  logic        clk;
  logic        interrupt_reset_n;
  logic        exc_valid;
  logic        SNaN, QNaN, div_by_zero, overflow, underflow, inexact;
  logic        mask_we;
  logic [5:0]  mask_wdata;
  logic        status_clr;
  logic [5:0]  status_clr_data;
  logic        int_ack;
  logic        int_eoi;
  logic        irq;
  logic [2:0]  irq_cause;
  logic [31:0] irq_vector;
  logic        in_service;
  logic [5:0]  pending;
  logic [5:0]  sticky_status;
  logic [5:0]  overrun;
  logic [5:0]  mask;

  int vectors_applied;
  int miscompares;

  fp_exception_int_ctrl #(
    .PC_WIDTH     (32),
    .VECTOR_BASE  (32'h0000_0100),
    .VECTOR_STRIDE(4)
  ) dut (
    .clk              (clk),
    .interrupt_reset_n(interrupt_reset_n),
    .exc_valid        (exc_valid),
    .SNaN             (SNaN),
    .QNaN             (QNaN),
    .div_by_zero      (div_by_zero),
    .overflow         (overflow),
    .underflow        (underflow),
    .inexact          (inexact),
    .mask_we          (mask_we),
    .mask_wdata       (mask_wdata),
    .status_clr       (status_clr),
    .status_clr_data  (status_clr_data),
    .int_ack          (int_ack),
    .int_eoi          (int_eoi),
    .irq              (irq),
    .irq_cause        (irq_cause),
    .irq_vector       (irq_vector),
    .in_service       (in_service),
    .pending          (pending),
    .sticky_status    (sticky_status),
    .overrun          (overrun),
    .mask             (mask)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_valid = 0; SNaN = 0; QNaN = 0; div_by_zero = 0; overflow = 0; underflow = 0; inexact = 0;
    mask_we = 0; mask_wdata = 6'b0; status_clr = 0; status_clr_data = 6'b0; int_ack = 0; int_eoi = 0;
  endtask

  // flags in bit order [5]SNaN .. [0]inexact
  task automatic drive_flags(input logic [5:0] f);
    exc_valid = 1'b1;
    {SNaN, QNaN, div_by_zero, overflow, underflow, inexact} = f;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, ".irq"}, 32'(irq), 32'd0);
    check({tag, ".cause"}, 32'(irq_cause), 32'd0);
    check({tag, ".vector"}, irq_vector, 32'd0);
    check({tag, ".in_service"}, 32'(in_service), 32'd0);
    check({tag, ".pending"}, 32'(pending), 32'd0);
    check({tag, ".sticky"}, 32'(sticky_status), 32'd0);
    check({tag, ".overrun"}, 32'(overrun), 32'd0);
    check({tag, ".mask"}, 32'(mask), 32'h3f);
  endtask

  task automatic check_req(input string tag, input logic [2:0] cause, input logic [31:0] vec);
    check({tag, ".irq"}, 32'(irq), 32'd1);
    check({tag, ".cause"}, 32'(irq_cause), 32'(cause));
    check({tag, ".vector"}, irq_vector, vec);
    check({tag, ".in_service"}, 32'(in_service), 32'd0);
  endtask

  task automatic ack_then_eoi();
    int_ack = 1; step(); int_ack = 0;
    int_eoi = 1; step(); int_eoi = 0;
  endtask

  initial begin
    vectors_applied = 0;
    miscompares = 0;
    clear_inputs();
    interrupt_reset_n = 0;
    step();
    step();
    check_idle_reset("reset");

    interrupt_reset_n = 1;
    int_ack = 1; int_eoi = 1;
    step();
    clear_inputs();
    check("stray_ack_idle.in_service", 32'(in_service), 32'd0);
    check("stray_ack_idle.irq", 32'(irq), 32'd0);

    mask_we = 1; mask_wdata = 6'b000000;
    step(); clear_inputs();
    check("unmask.mask", 32'(mask), 32'h00);

    // single overflow: pending after t, irq after t+1
    drive_flags(6'b000100);
    step(); clear_inputs();
    check("ovf.pending_t", 32'(pending), 32'h04);
    check("ovf.irq_t", 32'(irq), 32'd0);
    step();
    check_req("ovf.req", 3'd4, 32'h10C);
    check("ovf.sticky", 32'(sticky_status), 32'h04);
    int_ack = 1; step(); int_ack = 0;
    check("ovf.ack.irq", 32'(irq), 32'd0);
    check("ovf.ack.in_service", 32'(in_service), 32'd1);
    check("ovf.ack.pending", 32'(pending), 32'h00);
    check("ovf.ack.cause", 32'(irq_cause), 32'd4);
    int_eoi = 1; step(); int_eoi = 0;
    check("ovf.eoi.in_service", 32'(in_service), 32'd0);
    check("ovf.eoi.cause", 32'(irq_cause), 32'd0);
    check("ovf.eoi.vector", irq_vector, 32'd0);
    status_clr = 1; status_clr_data = 6'b111111;
    step(); clear_inputs();
    check("clr_all.sticky", 32'(sticky_status), 32'h00);

    // SNaN + inexact together: SNaN first, then inexact
    drive_flags(6'b100001);
    step(); clear_inputs();
    check("pair.pending", 32'(pending), 32'h21);
    step();
    check_req("pair.req1", 3'd1, 32'h100);
    int_ack = 1; step(); int_ack = 0;
    check("pair.ack.pending", 32'(pending), 32'h01);
    int_eoi = 1; step(); int_eoi = 0;
    check("pair.eoi.irq", 32'(irq), 32'd0);
    step();
    check_req("pair.req2", 3'd6, 32'h114);
    check("pair.sticky", 32'(sticky_status), 32'h21);
    ack_then_eoi();
    check("pair.sticky_held", 32'(sticky_status), 32'h21);
    // clear and re-flag inexact on the same edge: set wins
    status_clr = 1; status_clr_data = 6'b100001;
    drive_flags(6'b000001);
    step(); clear_inputs();
    check("clr_vs_set.sticky", 32'(sticky_status), 32'h01);
    step();
    check_req("clr_vs_set.req", 3'd6, 32'h114);
    ack_then_eoi();
    status_clr = 1; status_clr_data = 6'b100001;
    step(); clear_inputs();
    check("clr_pair.sticky", 32'(sticky_status), 32'h00);

    // masked div_by_zero held pending until unmasked
    mask_we = 1; mask_wdata = 6'b111111;
    step(); clear_inputs();
    drive_flags(6'b001000);
    step(); clear_inputs();
    step();
    check("masked.irq", 32'(irq), 32'd0);
    check("masked.pending", 32'(pending), 32'h08);
    mask_we = 1; mask_wdata = 6'b110111;
    step(); clear_inputs();
    check("unmask_edge.irq", 32'(irq), 32'd0);
    step();
    check_req("unmasked.req", 3'd3, 32'h108);
    ack_then_eoi();
    mask_we = 1; mask_wdata = 6'b000000;
    step(); clear_inputs();

    // overflow re-flagged while in service
    drive_flags(6'b000100);
    step(); clear_inputs();
    step();
    check_req("svc.req", 3'd4, 32'h10C);
    int_ack = 1; step(); int_ack = 0;
    drive_flags(6'b000100);
    step(); clear_inputs();
    check("svc.reflag1.pending", 32'(pending), 32'h04);
    check("svc.reflag1.overrun", 32'(overrun), 32'h00);
    drive_flags(6'b000100);
    step(); clear_inputs();
    check("svc.reflag2.overrun", 32'(overrun), 32'h04);
    check("svc.reflag2.in_service", 32'(in_service), 32'd1);
    check("svc.reflag2.irq", 32'(irq), 32'd0);
    check("svc.reflag2.cause", 32'(irq_cause), 32'd4);
    int_eoi = 1; step(); int_eoi = 0;
    step();
    check_req("svc.next_req", 3'd4, 32'h10C);

    // in REQ: stray eoi, then SNaN does not preempt, then reset pulse
    int_eoi = 1; step(); int_eoi = 0;
    check_req("req.stray_eoi", 3'd4, 32'h10C);
    drive_flags(6'b100000);
    step(); clear_inputs();
    check_req("req.no_preempt", 3'd4, 32'h10C);
    check("req.no_preempt.pending", 32'(pending), 32'h24);
    mask_we = 1; mask_wdata = 6'b111111;
    step(); clear_inputs();
    check_req("req.mask_no_withdraw", 3'd4, 32'h10C);
    interrupt_reset_n = 0;
    step();
    interrupt_reset_n = 1;
    check_idle_reset("mid_reset");

    // ack on the same edge the serviced bit is re-flagged, plus a different bit
    mask_we = 1; mask_wdata = 6'b000000;
    step(); clear_inputs();
    drive_flags(6'b000100);
    step(); clear_inputs();
    step();
    check_req("ackset.req", 3'd4, 32'h10C);
    int_ack = 1;
    drive_flags(6'b000110);
    step(); clear_inputs();
    check("ackset.pending", 32'(pending), 32'h06);
    check("ackset.overrun", 32'(overrun), 32'h00);
    check("ackset.in_service", 32'(in_service), 32'd1);
    int_eoi = 1; step(); int_eoi = 0;
    step();
    check_req("ackset.next_req", 3'd4, 32'h10C);
    int_ack = 1; step(); int_ack = 0;
    check("ackset2.pending", 32'(pending), 32'h02);
    int_eoi = 1; step(); int_eoi = 0;
    step();
    check_req("ackset.underflow_req", 3'd5, 32'h110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
